// File: rtl/nibble_serial_sub_pkg.sv
// Shared types and sizing helpers for the nibble-serial subtractor.
package nibble_serial_sub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  function automatic int unsigned nib_count(input int unsigned width);
    return width / 4;
  endfunction

  // Index register needs at least one bit even when there is a single nibble.
  function automatic int unsigned idx_width(input int unsigned width);
    return (width / 4 > 1) ? $clog2(width / 4) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_sub_bla_4.sv
// Combinational 4-bit borrow-lookahead subtract slice with group generate/propagate.
module bla_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout,
  output logic       gm,
  output logic       pm
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Borrow is generated when a=0,b=1 and propagated when the bits are equal.
  assign g = ~a & b;
  assign p = ~(a ^ b);

  assign c[0] = bin;
  assign c[1] = g[0] | (p[0] & bin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);

  assign gm = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pm = &p;

  assign d    = a ^ b ^ c;
  assign bout = gm | (pm & bin);

endmodule

// File: rtl/nibble_serial_sub.sv
// Multi-cycle unsigned subtractor: one nibble of a - b per clock through a shared slice.
module nibble_serial_sub
  import nibble_serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned Nib  = nib_count(WIDTH);
  localparam int unsigned IdxW = idx_width(WIDTH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_q, borrow_d;
  logic              borrow_out_q, borrow_out_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  logic [3:0]        nib_a;
  logic [3:0]        nib_b;
  logic [3:0]        nib_d;
  logic              nib_bout;
  logic              nib_gm;
  logic              nib_pm;
  logic              last_nib;

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int k = 0; k < int'(Nib); k++) begin
      if (idx_q == IdxW'(k)) begin
        nib_a = a_q[4*k +: 4];
        nib_b = b_q[4*k +: 4];
      end
    end
  end

  bla_4 u_bla (
    .a    (nib_a),
    .b    (nib_b),
    .bin  (borrow_q),
    .d    (nib_d),
    .bout (nib_bout),
    .gm   (nib_gm),
    .pm   (nib_pm)
  );

  assign last_nib = (idx_q == IdxW'(Nib - 1));

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    diff_d       = diff_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
    idx_d        = idx_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = 1'b0;
          idx_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        for (int k = 0; k < int'(Nib); k++) begin
          if (idx_q == IdxW'(k)) begin
            diff_d[4*k +: 4] = nib_d;
          end
        end
        borrow_d = nib_bout;
        if (last_nib) begin
          borrow_out_d = nib_bout;
          idx_d        = '0;
          state_d      = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      diff_q       <= diff_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
      idx_q        <= idx_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

  // Group terms must agree with the ripple-style bout the datapath consumes.
  slice_group_consistent: assert property (@(posedge clk) disable iff (rst)
    nib_bout == (nib_gm | (nib_pm & borrow_q)));

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed and model-checked bench for nibble_serial_sub at WIDTH 4, 16 and 32.
module tb_nibble_serial_sub;

  logic        clk;
  logic        rst;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  bo;
  logic [3:0]  a4, b4, d4;
  logic [15:0] a16, b16, d16;
  logic [31:0] a32, b32, d32;

  int tests;
  int fails;
  int cyc;

  nibble_serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a4), .b(b4),
    .out_valid(ov[0]), .out_ready(ordy[0]), .diff(d4), .borrow_out(bo[0])
  );

  nibble_serial_sub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a16), .b(b16),
    .out_valid(ov[1]), .out_ready(ordy[1]), .diff(d16), .borrow_out(bo[1])
  );

  nibble_serial_sub #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a32), .b(b32),
    .out_valid(ov[2]), .out_ready(ordy[2]), .diff(d32), .borrow_out(bo[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ab(input int s, input logic [31:0] av, input logic [31:0] bv);
    case (s)
      0: begin a4 = av[3:0]; b4 = bv[3:0]; end
      1: begin a16 = av[15:0]; b16 = bv[15:0]; end
      default: begin a32 = av; b32 = bv; end
    endcase
  endtask

  function automatic logic [31:0] diff_of(input int s);
    case (s)
      0: return {28'd0, d4};
      1: return {16'd0, d16};
      default: return d32;
    endcase
  endfunction

  // Full transaction with latency, result and handshake-return checks.
  task automatic run_op(input int s, input logic [31:0] av, input logic [31:0] bv,
                        input string tag);
    int          w;
    int          n;
    logic [31:0] mask;
    logic [31:0] exp_d;
    logic        exp_b;
    w     = (s == 0) ? 4 : (s == 1) ? 16 : 32;
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    exp_d = (av - bv) & mask;
    exp_b = ((av & mask) < (bv & mask));
    n = 0;
    while (!ir[s] && n < 50) begin @(negedge clk); n++; end
    check({tag, ":idle"}, 64'(ir[s]), 64'd1);
    set_ab(s, av, bv);
    iv[s] = 1'b1;
    @(negedge clk);
    iv[s] = 1'b0;
    set_ab(s, ~av, ~bv);
    n = 0;
    while (!ov[s] && n < 50) begin @(negedge clk); n++; end
    check({tag, ":lat"}, 64'(n), 64'(w / 4));
    check({tag, ":diff"}, 64'(diff_of(s)), 64'(exp_d));
    check({tag, ":bout"}, 64'(bo[s]), 64'(exp_b));
    ordy[s] = 1'b1;
    @(negedge clk);
    ordy[s] = 1'b0;
    check({tag, ":ret"}, 64'({ir[s], ov[s]}), 64'b10);
  endtask

  initial begin
    int n;
    int c0;
    logic bad;
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    iv    = '0;
    ordy  = '0;
    a4 = '0; b4 = '0; a16 = '0; b16 = '0; a32 = '0; b32 = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ir), 64'b111);
    check("rst_valid", 64'(ov), 64'b000);
    check("rst_diff", 64'(d16), 64'd0);
    check("rst_bout", 64'(bo), 64'b000);
    rst = 1'b0;
    @(negedge clk);

    run_op(1, 32'h1234, 32'h0235, "d16_a");
    run_op(1, 32'h0000, 32'h0001, "d16_b");
    run_op(1, 32'hABCD, 32'hABCD, "d16_c");
    run_op(1, 32'hFFFF, 32'h0000, "d16_d");
    run_op(1, 32'h8000, 32'hFFFF, "d16_e");
    run_op(0, 32'h3, 32'h5, "d4_a");
    run_op(0, 32'hF, 32'h1, "d4_b");
    run_op(2, 32'h0000_0000, 32'h0000_0001, "d32_a");
    run_op(2, 32'h1000_0000, 32'h0FFF_FFFF, "d32_b");

    // Hold the result off for 10 cycles while a new request waits.
    a16 = 16'h00F0; b16 = 16'h000F; iv[1] = 1'b1;
    @(negedge clk);
    a16 = 16'h1111; b16 = 16'h0000;
    n = 0;
    while (!ov[1] && n < 50) begin @(negedge clk); n++; end
    check("hold_lat", 64'(n), 64'd4);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ir[1] || !ov[1] || d16 != 16'h00E1 || bo[1]) bad = 1'b1;
    end
    check("hold_stable", 64'(bad), 64'd0);
    iv[1] = 1'b0; ordy[1] = 1'b1;
    @(negedge clk);
    ordy[1] = 1'b0;
    check("hold_ret", 64'({ir[1], ov[1]}), 64'b10);
    @(negedge clk);
    check("hold_noacc", 64'({ir[1], ov[1]}), 64'b10);

    // Reset in the second CALC cycle discards the operation.
    a16 = 16'hFFFF; b16 = 16'h0001; iv[1] = 1'b1;
    @(negedge clk);
    iv[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(ir[1]), 64'd1);
    check("midrst_valid", 64'(ov[1]), 64'd0);
    check("midrst_diff", 64'(d16), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ov[1] || !ir[1]) bad = 1'b1;
    end
    check("midrst_quiet", 64'(bad), 64'd0);
    run_op(1, 32'h0005, 32'h0003, "after_rst");

    // Back-to-back with in_valid and out_ready held high.
    a16 = 16'h0042; b16 = 16'h0001; iv[1] = 1'b1; ordy[1] = 1'b1;
    n = 0;
    while (!ir[1] && n < 50) begin @(negedge clk); n++; end
    c0 = cyc;
    @(negedge clk);
    n = 0;
    while (!ir[1] && n < 50) begin @(negedge clk); n++; end
    iv[1] = 1'b0;
    check("ii", 64'(cyc - c0), 64'd6);
    n = 0;
    while (!ir[1] && n < 50) begin @(negedge clk); n++; end
    ordy[1] = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      run_op(1, $urandom, $urandom, "r16");
    end
    for (int i = 0; i < 1000; i++) begin
      run_op(2, $urandom, $urandom, "r32");
    end
    for (int i = 0; i < 50; i++) begin
      run_op(0, $urandom, $urandom, "r4");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
